// File: rtl/memory_round_ctrl.sv
// Memory-game round controller: generates a pseudo-random digit sequence, presents it,
// checks the keypad answer and keeps a BCD score until a win or a timer abort.
module memory_round_ctrl #(
    parameter int unsigned SEQ_LEN    = 4,
    parameter int unsigned TARGET     = 10,
    parameter logic [23:0] SHOW_TICKS = 24'd12_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       key_press,
    input  logic [3:0] key_code,
    input  logic       gameendtimeover,
    output logic [3:0] show_digit,
    output logic       show_en,
    output logic [3:0] score1,
    output logic [3:0] score10,
    output logic       gameendccount,
    output logic [2:0] game_state
);

    localparam int unsigned      IDX_W     = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SEQ_LEN - 1);
    localparam logic [3:0]       TGT_ONES  = 4'(TARGET % 10);
    localparam logic [3:0]       TGT_TENS  = 4'(TARGET / 10);
    localparam logic [23:0]      LAST_TICK = SHOW_TICKS - 24'd1;
    localparam logic [15:0]      LFSR_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GEN   = 3'd1,
        ST_SHOW  = 3'd2,
        ST_INPUT = 3'd3,
        ST_CHECK = 3'd4,
        ST_WIN   = 3'd5,
        ST_OVER  = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_start_sync;
    logic [2:0]        r_key_sync;
    logic [15:0]       r_lfsr;
    logic [3:0]        r_seq [SEQ_LEN];
    logic [3:0]        w_seq_nxt [SEQ_LEN];
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [IDX_W-1:0]  w_idx_inc;
    logic [23:0]       r_tick;
    logic [23:0]       w_tick_nxt;
    logic              r_miss;
    logic              w_miss_nxt;
    logic [3:0]        r_show_digit;
    logic [3:0]        w_show_digit_nxt;
    logic              r_show_en;
    logic              w_show_en_nxt;
    logic [3:0]        r_score1;
    logic [3:0]        w_score1_nxt;
    logic [3:0]        r_score10;
    logic [3:0]        w_score10_nxt;
    logic              r_win;
    logic              w_win_nxt;

    logic              w_start_edge;
    logic              w_key_edge;
    logic              w_lfsr_fb;
    logic [3:0]        w_digit;
    logic [3:0]        w_inc_ones;
    logic [3:0]        w_inc_tens;
    logic              w_inc_hits_target;

    // Two-flop synchronizers with a third stage kept for rising-edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_start_sync <= '0;
            r_key_sync   <= '0;
        end else begin
            r_start_sync <= {r_start_sync[1:0], start};
            r_key_sync   <= {r_key_sync[1:0], key_press};
        end
    end

    assign w_start_edge = r_start_sync[1] & ~r_start_sync[2];
    assign w_key_edge   = r_key_sync[1] & ~r_key_sync[2];

    // Free-running LFSR; the digit is its low nibble folded into 0..9
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_digit   = (r_lfsr[3:0] < 4'd10) ? r_lfsr[3:0] : (r_lfsr[3:0] - 4'd10);

    assign w_idx_inc         = r_idx + IDX_W'(1);
    assign w_inc_ones        = (r_score1 == 4'd9) ? 4'd0 : (r_score1 + 4'd1);
    assign w_inc_tens        = (r_score1 == 4'd9) ? (r_score10 + 4'd1) : r_score10;
    assign w_inc_hits_target = (w_inc_tens == TGT_TENS) && (w_inc_ones == TGT_ONES);

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_seq        <= '{default: '0};
            r_idx        <= '0;
            r_tick       <= '0;
            r_miss       <= 1'b0;
            r_show_digit <= 4'd0;
            r_show_en    <= 1'b0;
            r_score1     <= 4'd0;
            r_score10    <= 4'd0;
            r_win        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_seq        <= w_seq_nxt;
            r_idx        <= w_idx_nxt;
            r_tick       <= w_tick_nxt;
            r_miss       <= w_miss_nxt;
            r_show_digit <= w_show_digit_nxt;
            r_show_en    <= w_show_en_nxt;
            r_score1     <= w_score1_nxt;
            r_score10    <= w_score10_nxt;
            r_win        <= w_win_nxt;
        end
    end

    // Next-state and next-output logic; display outputs are derived from the next state
    always_comb begin
        w_state_nxt      = r_state;
        w_seq_nxt        = r_seq;
        w_idx_nxt        = r_idx;
        w_tick_nxt       = r_tick;
        w_miss_nxt       = r_miss;
        w_show_digit_nxt = 4'd0;
        w_show_en_nxt    = 1'b0;
        w_score1_nxt     = r_score1;
        w_score10_nxt    = r_score10;
        w_win_nxt        = r_win;

        case (r_state)
            ST_IDLE: begin
                if (w_start_edge) begin
                    w_state_nxt   = ST_GEN;
                    w_idx_nxt     = '0;
                    w_score1_nxt  = 4'd0;
                    w_score10_nxt = 4'd0;
                end
            end

            ST_GEN: begin
                w_seq_nxt[r_idx] = w_digit;
                if (gameendtimeover) begin
                    w_state_nxt = ST_OVER;
                end else if (r_idx == LAST_IDX) begin
                    w_state_nxt      = ST_SHOW;
                    w_idx_nxt        = '0;
                    w_tick_nxt       = '0;
                    w_show_en_nxt    = 1'b1;
                    w_show_digit_nxt = w_seq_nxt[0];
                end else begin
                    w_idx_nxt = w_idx_inc;
                end
            end

            ST_SHOW: begin
                if (gameendtimeover) begin
                    w_state_nxt = ST_OVER;
                end else if (r_tick == LAST_TICK) begin
                    w_tick_nxt = '0;
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = ST_INPUT;
                        w_idx_nxt   = '0;
                        w_miss_nxt  = 1'b0;
                    end else begin
                        w_idx_nxt        = w_idx_inc;
                        w_show_en_nxt    = 1'b1;
                        w_show_digit_nxt = r_seq[w_idx_inc];
                    end
                end else begin
                    w_tick_nxt       = r_tick + 24'd1;
                    w_show_en_nxt    = 1'b1;
                    w_show_digit_nxt = r_seq[r_idx];
                end
            end

            ST_INPUT: begin
                if (gameendtimeover) begin
                    w_state_nxt = ST_OVER;
                end else if (w_key_edge) begin
                    w_miss_nxt = r_miss | (key_code != r_seq[r_idx]);
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = ST_CHECK;
                    end else begin
                        w_idx_nxt = w_idx_inc;
                    end
                end
            end

            ST_CHECK: begin
                if (gameendtimeover) begin
                    w_state_nxt = ST_OVER;
                end else begin
                    w_state_nxt = ST_GEN;
                    w_idx_nxt   = '0;
                    if (!r_miss) begin
                        w_score1_nxt  = w_inc_ones;
                        w_score10_nxt = w_inc_tens;
                        if (w_inc_hits_target) begin
                            w_state_nxt = ST_WIN;
                            w_win_nxt   = 1'b1;
                        end
                    end
                end
            end

            ST_WIN, ST_OVER: begin
                w_state_nxt = r_state;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign show_digit    = r_show_digit;
    assign show_en       = r_show_en;
    assign score1        = r_score1;
    assign score10       = r_score10;
    assign gameendccount = r_win;
    assign game_state    = r_state;

endmodule

// File: tb/tb_memory_round_ctrl.sv
// Bench for memory_round_ctrl: two instances (TARGET=3 and TARGET=12) share one stimulus
// stream and are checked every cycle against a round-level model of the game.
`timescale 1ns/1ps
module tb_memory_round_ctrl;

    localparam int SEQ_LEN    = 4;
    localparam int SHOW_TICKS = 4;
    localparam int SHOW_CYC   = SEQ_LEN * SHOW_TICKS;
    localparam int TGT_A      = 3;
    localparam int TGT_B      = 12;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       key_press = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       gameendtimeover = 1'b0;

    logic [3:0] a_digit, a_s1, a_s10, b_digit, b_s1, b_s10;
    logic       a_en, a_win, b_en, b_win;
    logic [2:0] a_st, b_st;

    memory_round_ctrl #(.SEQ_LEN(SEQ_LEN), .TARGET(TGT_A), .SHOW_TICKS(24'd4)) dut_a (
        .clk(clk), .reset(reset), .start(start), .key_press(key_press), .key_code(key_code),
        .gameendtimeover(gameendtimeover), .show_digit(a_digit), .show_en(a_en),
        .score1(a_s1), .score10(a_s10), .gameendccount(a_win), .game_state(a_st));

    memory_round_ctrl #(.SEQ_LEN(SEQ_LEN), .TARGET(TGT_B), .SHOW_TICKS(24'd4)) dut_b (
        .clk(clk), .reset(reset), .start(start), .key_press(key_press), .key_code(key_code),
        .gameendtimeover(gameendtimeover), .show_digit(b_digit), .show_en(b_en),
        .score1(b_s1), .score10(b_s10), .gameendccount(b_win), .game_state(b_st));

    always #5 clk = ~clk;

    // Reference pseudo-random source: advances on every clock from the seed
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge reset) begin
        if (!reset) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    int         n_checks = 0;
    int         n_fail = 0;
    int         a_score = 0;
    int         b_score = 0;
    bit         over = 1'b0;
    logic [3:0] exp_seq [SEQ_LEN];

    typedef struct {
        int wrong_pos;
        int exp_a_score;
        int exp_a_state;
        int exp_b10;
        int exp_b1;
        int exp_b_state;
    } row_t;
    row_t rows [13];

    function automatic logic [3:0] to_digit(input logic [15:0] l);
        return 4'(int'(l[3:0]) % 10);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic chk_dut(input string tag, input int score, input int target,
                           input int st, input int en, input int dig,
                           input logic [2:0] st_i, input logic en_i, input logic [3:0] dig_i,
                           input logic [3:0] s10_i, input logic [3:0] s1_i, input logic win_i);
        int est, een, edig;
        bit won;
        won = (score >= target);
        if (over)     begin est = 6; een = 0; edig = 0; end
        else if (won) begin est = 5; een = 0; edig = 0; end
        else          begin est = st; een = en; edig = dig; end
        chk({tag, ".game_state"},    32'(st_i),  32'(est));
        chk({tag, ".show_en"},       32'(en_i),  32'(een));
        chk({tag, ".show_digit"},    32'(dig_i), 32'(edig));
        chk({tag, ".score10"},       32'(s10_i), 32'(score / 10));
        chk({tag, ".score1"},        32'(s1_i),  32'(score % 10));
        chk({tag, ".gameendccount"}, 32'(win_i), 32'(won && !over));
    endtask

    task automatic chk_all(input int st, input int en, input int dig);
        chk_dut("A", a_score, TGT_A, st, en, dig, a_st, a_en, a_digit, a_s10, a_s1, a_win);
        chk_dut("B", b_score, TGT_B, st, en, dig, b_st, b_en, b_digit, b_s10, b_s1, b_win);
    endtask

    task automatic apply_reset();
        #2;
        reset = 1'b0;
        start = 1'b0;
        key_press = 1'b0;
        gameendtimeover = 1'b0;
        a_score = 0;
        b_score = 0;
        over = 1'b0;
        #1;
        chk_all(0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk); chk_all(0, 0, 0);
        @(negedge clk); chk_all(0, 0, 0);
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic poke_start(input int st);
        start = 1'b1;
        repeat (2) begin @(negedge clk); chk_all(st, 0, 0); end
        start = 1'b0;
        repeat (4) begin @(negedge clk); chk_all(st, 0, 0); end
    endtask

    // Starts on the first GEN cycle; show_cycles < SHOW_CYC stops mid-presentation
    task automatic run_gen_show(input int show_cycles);
        for (int i = 0; i < SEQ_LEN; i++) begin
            exp_seq[i] = to_digit(m_lfsr);
            chk_all(1, 0, 0);
            @(negedge clk);
        end
        for (int c = 0; c < show_cycles; c++) begin
            chk_all(2, 1, int'(exp_seq[c / SHOW_TICKS]));
            @(negedge clk);
        end
        if (show_cycles == SHOW_CYC) chk_all(3, 0, 0);
    endtask

    task automatic key_in(input logic [3:0] code);
        key_code = code;
        key_press = 1'b1;
        repeat (2) begin @(negedge clk); chk_all(3, 0, 0); end
        @(negedge clk);
        key_press = 1'b0;
    endtask

    task automatic enter_keys(input int nkeys, input int wrong_pos, output bit all_ok);
        logic [3:0] k;
        int gap;
        all_ok = 1'b1;
        for (int i = 0; i < nkeys; i++) begin
            k = exp_seq[i];
            if (i == wrong_pos) k = 4'((int'(exp_seq[i]) + 1 + int'($urandom_range(0, 8))) % 10);
            if (k != exp_seq[i]) all_ok = 1'b0;
            key_in(k);
            if (i != SEQ_LEN - 1) begin
                gap = 3 + int'($urandom_range(0, 3));
                chk_all(3, 0, 0);
                repeat (gap) begin @(negedge clk); chk_all(3, 0, 0); end
            end
        end
    endtask

    task automatic finish_round(input bit to, input bit ok);
        chk_all(4, 0, 0);
        if (to) gameendtimeover = 1'b1;
        @(negedge clk);
        if (to) over = 1'b1;
        else if (ok) begin
            if (a_score < TGT_A) a_score++;
            if (b_score < TGT_B) b_score++;
        end
        chk_all(1, 0, 0);
    endtask

    task automatic play_round(input int wrong_pos, input bit to);
        bit ok;
        run_gen_show(SHOW_CYC);
        enter_keys(SEQ_LEN, wrong_pos, ok);
        finish_round(to, ok);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        bit ok;

        rows[0]  = '{-1, 1, 1, 0, 1, 1};
        rows[1]  = '{ 1, 1, 1, 0, 1, 1};
        rows[2]  = '{-1, 2, 1, 0, 2, 1};
        rows[3]  = '{-1, 3, 5, 0, 3, 1};
        rows[4]  = '{-1, 3, 5, 0, 4, 1};
        rows[5]  = '{-1, 3, 5, 0, 5, 1};
        rows[6]  = '{-1, 3, 5, 0, 6, 1};
        rows[7]  = '{-1, 3, 5, 0, 7, 1};
        rows[8]  = '{-1, 3, 5, 0, 8, 1};
        rows[9]  = '{-1, 3, 5, 0, 9, 1};
        rows[10] = '{-1, 3, 5, 1, 0, 1};
        rows[11] = '{-1, 3, 5, 1, 1, 1};
        rows[12] = '{-1, 3, 5, 1, 2, 5};

        // Reset state, then an idle stretch with stray key and timer activity
        repeat (2) @(negedge clk);
        chk_all(0, 0, 0);
        reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c == 5)  begin key_code = 4'(int'($urandom_range(0, 9))); key_press = 1'b1; end
            if (c == 10) key_press = 1'b0;
            gameendtimeover = (c >= 12 && c < 15);
            @(negedge clk);
            chk_all(0, 0, 0);
        end
        gameendtimeover = 1'b0;

        // Main game: A wins at 3, B carries on to 12 through a BCD carry
        apply_reset();
        repeat (int'($urandom_range(1, 5))) @(negedge clk);
        do_start();
        for (int r = 0; r < 13; r++) begin
            run_gen_show(SHOW_CYC);
            if (a_score >= TGT_A) poke_start(3);
            enter_keys(SEQ_LEN, rows[r].wrong_pos, ok);
            finish_round(1'b0, ok);
            chk("row A score1",  32'(a_s1),  32'(rows[r].exp_a_score));
            chk("row A score10", 32'(a_s10), 32'(0));
            chk("row A state",   32'(a_st),  32'(rows[r].exp_a_state));
            chk("row B score10", 32'(b_s10), 32'(rows[r].exp_b10));
            chk("row B score1",  32'(b_s1),  32'(rows[r].exp_b1));
            chk("row B state",   32'(b_st),  32'(rows[r].exp_b_state));
        end
        key_in(4'd7);
        chk_all(5, 0, 0);
        poke_start(5);
        chk("B win sticky", 32'(b_win), 32'(1));

        // Timer expiry in INPUT after two keys
        apply_reset();
        do_start();
        run_gen_show(SHOW_CYC);
        enter_keys(2, -1, ok);
        gameendtimeover = 1'b1;
        @(negedge clk);
        over = 1'b1;
        chk_all(3, 0, 0);
        chk("over state after input timeout", 32'(b_st), 32'(6));
        gameendtimeover = 1'b0;
        key_in(exp_seq[2]);
        key_in(exp_seq[3]);
        poke_start(0);
        chk_all(0, 0, 0);

        // Timer expiry coinciding with CHECK after a correct answer
        apply_reset();
        do_start();
        play_round(-1, 1'b0);
        play_round(-1, 1'b1);
        chk("check timeout state",  32'(b_st), 32'(6));
        chk("check timeout score1", 32'(b_s1), 32'(1));
        repeat (3) begin @(negedge clk); chk_all(0, 0, 0); end

        // Reset in the middle of the fifth round's presentation
        apply_reset();
        do_start();
        for (int r = 0; r < 4; r++) play_round(-1, 1'b0);
        chk("pre-reset B score1", 32'(b_s1), 32'(4));
        run_gen_show(6);
        chk("mid-show enable", 32'(b_en), 32'(1));
        apply_reset();
        chk("post-reset B score1", 32'(b_s1), 32'(0));
        chk("post-reset A win",    32'(a_win), 32'(0));
        repeat (3) begin @(negedge clk); chk_all(0, 0, 0); end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
